// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single ddr_ctrl block port between the cache
// manage unit (C) and the block DMA engine (D). C has fixed priority. D is
// forced through after MAX_CONSEC consecutive C grants while it waits. Only one
// transaction is in flight at a time, and a one-cycle RELEASE gap follows each
// completion.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned BLOCK_W    = 256,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c_en,
  input  logic               c_write,
  input  logic [ADDR_W-1:0]  c_addr,
  input  logic [BLOCK_W-1:0] c_data,
  output logic               c_rdy,
  input  logic               d_en,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_data,
  output logic               d_rdy,
  output logic [BLOCK_W-1:0] block_out,
  output logic               ram_en,
  output logic               ram_write,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [BLOCK_W-1:0] data_to_ram,
  input  logic               ram_rdy,
  input  logic [BLOCK_W-1:0] block_from_ram
);

  localparam int unsigned      CNT_W   = $clog2(MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_C  = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_D = 1'b1;

  logic [1:0]         state_q,       state_d;
  logic [CNT_W-1:0]   starve_cnt_q,  starve_cnt_d;
  logic               last_owner_q,  last_owner_d;
  logic               ram_en_q,      ram_en_d;
  logic               ram_write_q,   ram_write_d;
  logic [ADDR_W-1:0]  ram_addr_q,    ram_addr_d;
  logic [BLOCK_W-1:0] data_to_ram_q, data_to_ram_d;
  logic [BLOCK_W-1:0] block_out_q,   block_out_d;
  logic               c_rdy_q,       c_rdy_d;
  logic               d_rdy_q,       d_rdy_d;
  logic               grant_d;

  // Arbitration, transaction capture and completion handshake.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    last_owner_d  = last_owner_q;
    ram_en_d      = ram_en_q;
    ram_write_d   = ram_write_q;
    ram_addr_d    = ram_addr_q;
    data_to_ram_d = data_to_ram_q;
    block_out_d   = block_out_q;
    c_rdy_d       = c_rdy_q;
    d_rdy_d       = d_rdy_q;
    grant_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (c_en || d_en) begin
          // D wins when it is alone, or when C has starved it long enough.
          grant_d  = d_en && (!c_en || (starve_cnt_q == CNT_MAX));
          ram_en_d = 1'b1;
          if (grant_d) begin
            state_d       = S_BUSY_D;
            last_owner_d  = OWNER_D;
            ram_write_d   = d_write;
            ram_addr_d    = d_addr;
            data_to_ram_d = d_data;
            starve_cnt_d  = '0;
          end else begin
            state_d       = S_BUSY_C;
            last_owner_d  = OWNER_C;
            ram_write_d   = c_write;
            ram_addr_d    = c_addr;
            data_to_ram_d = c_data;
            if (d_en) begin
              starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_ONE;
            end else begin
              starve_cnt_d = '0;
            end
          end
        end
      end
      S_BUSY_C, S_BUSY_D: begin
        // ram_* stay on their registered copies; live master inputs are ignored here.
        if (ram_rdy) begin
          state_d     = S_RELEASE;
          ram_en_d    = 1'b0;
          block_out_d = block_from_ram;
          c_rdy_d     = (last_owner_q == OWNER_C);
          d_rdy_d     = (last_owner_q == OWNER_D);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        c_rdy_d = 1'b0;
        d_rdy_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        ram_en_d = 1'b0;
        c_rdy_d  = 1'b0;
        d_rdy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      starve_cnt_q  <= '0;
      last_owner_q  <= OWNER_C;
      ram_en_q      <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_addr_q    <= '0;
      data_to_ram_q <= '0;
      block_out_q   <= '0;
      c_rdy_q       <= 1'b0;
      d_rdy_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      last_owner_q  <= last_owner_d;
      ram_en_q      <= ram_en_d;
      ram_write_q   <= ram_write_d;
      ram_addr_q    <= ram_addr_d;
      data_to_ram_q <= data_to_ram_d;
      block_out_q   <= block_out_d;
      c_rdy_q       <= c_rdy_d;
      d_rdy_q       <= d_rdy_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_write   = ram_write_q;
  assign ram_addr    = ram_addr_q;
  assign data_to_ram = data_to_ram_q;
  assign block_out   = block_out_q;
  assign c_rdy       = c_rdy_q;
  assign d_rdy       = d_rdy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a
// randomized run checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned BLOCK_W    = 256;
  localparam int unsigned MAX_CONSEC = 4;

  typedef struct packed {
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] data;
  } req_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               c_en, c_write, d_en, d_write;
  logic [ADDR_W-1:0]  c_addr, d_addr;
  logic [BLOCK_W-1:0] c_data, d_data;
  logic               c_rdy, d_rdy;
  logic [BLOCK_W-1:0] block_out;
  logic               ram_en, ram_write;
  logic [ADDR_W-1:0]  ram_addr;
  logic [BLOCK_W-1:0] data_to_ram;
  logic               ram_rdy;
  logic [BLOCK_W-1:0] block_from_ram;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BLOCK_W-1:0] last_blk = '0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .BLOCK_W(BLOCK_W),
    .MAX_CONSEC(MAX_CONSEC)
  ) dut (
    .clk(clk), .rst(rst),
    .c_en(c_en), .c_write(c_write), .c_addr(c_addr), .c_data(c_data), .c_rdy(c_rdy),
    .d_en(d_en), .d_write(d_write), .d_addr(d_addr), .d_data(d_data), .d_rdy(d_rdy),
    .block_out(block_out),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .data_to_ram(data_to_ram),
    .ram_rdy(ram_rdy), .block_from_ram(block_from_ram)
  );

  function automatic logic [BLOCK_W-1:0] rand_blk();
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < int'(BLOCK_W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wr   = 1'($urandom_range(0, 1));
    r.addr = ADDR_W'($urandom());
    r.data = rand_blk();
    return r;
  endfunction

  task automatic idle_inputs();
    c_en = 1'b0; c_write = 1'b0; c_addr = '0; c_data = '0;
    d_en = 1'b0; d_write = 1'b0; d_addr = '0; d_data = '0;
    ram_rdy = 1'b0; block_from_ram = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({ram_en, c_rdy, d_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=000", {ram_en, c_rdy, d_rdy});
    end
    n_tests++;
    if (block_out !== '0) begin n_fail++; $display("FAIL reset_block_out got=%h want=0", block_out); end
    n_tests++;
    if ({ram_write, ram_addr, data_to_ram} !== '0) begin
      n_fail++; $display("FAIL reset_ram_fields got=%b/%h/%h want=0", ram_write, ram_addr, data_to_ram);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_en got=%b want=0", ram_en); end
    last_blk = '0;
  endtask

  task automatic test_c_read();
    logic [BLOCK_W-1:0] a5, blk;
    a5 = {32{8'hA5}};
    c_en = 1'b1; c_write = 1'b0; c_addr = 30'h100; c_data = rand_blk();
    @(negedge clk);
    n_tests++;
    if ({ram_en, ram_write, c_rdy} !== 3'b100 || ram_addr !== 30'h100) begin
      n_fail++; $display("FAIL cread_grant got en=%b wr=%b rdy=%b addr=%h want 1/0/0/100", ram_en, ram_write, c_rdy, ram_addr);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (ram_en !== 1'b1) begin n_fail++; $display("FAIL cread_hold got=%b want=1", ram_en); end
    ram_rdy = 1'b1; block_from_ram = a5;
    @(negedge clk);
    ram_rdy = 1'b0; block_from_ram = rand_blk();
    n_tests++;
    if ({c_rdy, d_rdy, ram_en} !== 3'b100) begin
      n_fail++; $display("FAIL cread_done got rdy_c/d/en=%b want=100", {c_rdy, d_rdy, ram_en});
    end
    n_tests++;
    if (block_out !== a5) begin n_fail++; $display("FAIL cread_block got=%h want=%h", block_out, a5); end
    // C keeps c_en high with a new address: a gap cycle must precede the next grant.
    c_addr = 30'h104;
    @(negedge clk);
    n_tests++;
    if ({c_rdy, ram_en} !== 2'b00) begin n_fail++; $display("FAIL cread_gap got rdy/en=%b want=00", {c_rdy, ram_en}); end
    @(negedge clk);
    n_tests++;
    if (ram_en !== 1'b1 || ram_addr !== 30'h104) begin
      n_fail++; $display("FAIL cread_regrant got en=%b addr=%h want 1/104", ram_en, ram_addr);
    end
    blk = rand_blk();
    ram_rdy = 1'b1; block_from_ram = blk;
    @(negedge clk);
    ram_rdy = 1'b0; c_en = 1'b0;
    n_tests++;
    if (c_rdy !== 1'b1 || block_out !== blk) begin
      n_fail++; $display("FAIL cread_second got rdy=%b blk=%h want 1/%h", c_rdy, block_out, blk);
    end
    @(negedge clk);
    n_tests++;
    if (c_rdy !== 1'b0) begin n_fail++; $display("FAIL cread_pulse got=%b want=0", c_rdy); end
    last_blk = blk;
  endtask

  task automatic test_d_write();
    logic [BLOCK_W-1:0] pat, q, blk;
    pat = rand_blk();
    d_en = 1'b1; d_write = 1'b1; d_addr = 30'h3F0; d_data = pat;
    @(negedge clk);
    n_tests++;
    if ({ram_en, ram_write} !== 2'b11 || ram_addr !== 30'h3F0 || data_to_ram !== pat) begin
      n_fail++; $display("FAIL dwr_grant got en/wr=%b addr=%h data=%h want 11/3f0/%h", {ram_en, ram_write}, ram_addr, data_to_ram, pat);
    end
    // Owner and non-owner inputs change while D is in flight.
    d_data = ~pat; d_addr = '0; d_write = 1'b0;
    c_en = 1'b1; c_write = 1'b1; c_addr = 30'h55; c_data = rand_blk();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ram_en, ram_write} !== 2'b11 || ram_addr !== 30'h3F0 || data_to_ram !== pat || {c_rdy, d_rdy} !== 2'b00) begin
        n_fail++; $display("FAIL dwr_stable got en/wr=%b addr=%h data=%h rdy=%b want 11/3f0/%h/00", {ram_en, ram_write}, ram_addr, data_to_ram, {c_rdy, d_rdy}, pat);
      end
    end
    q = rand_blk();
    ram_rdy = 1'b1; block_from_ram = q;
    @(negedge clk);
    ram_rdy = 1'b0; d_en = 1'b0;
    n_tests++;
    if ({d_rdy, c_rdy} !== 2'b10 || block_out !== q) begin
      n_fail++; $display("FAIL dwr_done got d/c=%b blk=%h want 10/%h", {d_rdy, c_rdy}, block_out, q);
    end
    @(negedge clk);
    n_tests++;
    if ({d_rdy, ram_en} !== 2'b00) begin n_fail++; $display("FAIL dwr_release got rdy/en=%b want 00", {d_rdy, ram_en}); end
    @(negedge clk);
    n_tests++;
    if ({ram_en, ram_write} !== 2'b11 || ram_addr !== 30'h55) begin
      n_fail++; $display("FAIL dwr_c_next got en/wr=%b addr=%h want 11/55", {ram_en, ram_write}, ram_addr);
    end
    blk = rand_blk();
    ram_rdy = 1'b1; block_from_ram = blk;
    @(negedge clk);
    ram_rdy = 1'b0; c_en = 1'b0;
    n_tests++;
    if ({c_rdy, d_rdy} !== 2'b10) begin n_fail++; $display("FAIL dwr_c_done got c/d=%b want 10", {c_rdy, d_rdy}); end
    @(negedge clk);
    last_blk = blk;
  endtask

  task automatic test_spurious();
    logic [BLOCK_W-1:0] blk;
    ram_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      block_from_ram = rand_blk();
      @(negedge clk);
      n_tests++;
      if ({c_rdy, d_rdy, ram_en} !== 3'b000 || block_out !== last_blk) begin
        n_fail++; $display("FAIL spur_idle got rdy/en=%b blk=%h want 000/%h", {c_rdy, d_rdy, ram_en}, block_out, last_blk);
      end
    end
    ram_rdy = 1'b0;
    c_en = 1'b1; c_write = 1'b0; c_addr = 30'h200;
    @(negedge clk);
    blk = rand_blk();
    ram_rdy = 1'b1; block_from_ram = blk;
    @(negedge clk);
    c_en = 1'b0; block_from_ram = rand_blk();
    n_tests++;
    if (c_rdy !== 1'b1 || block_out !== blk) begin
      n_fail++; $display("FAIL spur_txn got rdy=%b blk=%h want 1/%h", c_rdy, block_out, blk);
    end
    // ram_rdy stays high across the RELEASE edge and the following IDLE edge.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      block_from_ram = rand_blk();
      n_tests++;
      if ({c_rdy, d_rdy, ram_en} !== 3'b000 || block_out !== blk) begin
        n_fail++; $display("FAIL spur_release got rdy/en=%b blk=%h want 000/%h", {c_rdy, d_rdy, ram_en}, block_out, blk);
      end
    end
    ram_rdy = 1'b0;
    last_blk = blk;
  endtask

  task automatic test_reset_mid();
    logic [BLOCK_W-1:0] blk;
    c_en = 1'b1; c_write = 1'b0; c_addr = 30'h300;
    @(negedge clk);
    n_tests++;
    if (ram_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got=%b want=1", ram_en); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({ram_en, c_rdy, d_rdy} !== 3'b000 || block_out !== '0) begin
      n_fail++; $display("FAIL rstmid_async got en/rdy=%b blk=%h want 000/0", {ram_en, c_rdy, d_rdy}, block_out);
    end
    c_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    d_en = 1'b1; d_write = 1'b0; d_addr = 30'h3A;
    @(negedge clk);
    n_tests++;
    if ({ram_en, ram_write} !== 2'b10 || ram_addr !== 30'h3A) begin
      n_fail++; $display("FAIL rstmid_dgrant got en/wr=%b addr=%h want 10/3a", {ram_en, ram_write}, ram_addr);
    end
    blk = rand_blk();
    ram_rdy = 1'b1; block_from_ram = blk;
    @(negedge clk);
    ram_rdy = 1'b0; d_en = 1'b0;
    n_tests++;
    if ({d_rdy, c_rdy} !== 2'b10 || block_out !== blk) begin
      n_fail++; $display("FAIL rstmid_ddone got d/c=%b blk=%h want 10/%h", {d_rdy, c_rdy}, block_out, blk);
    end
    @(negedge clk);
    last_blk = blk;
  endtask

  task automatic test_owner_drop();
    logic [BLOCK_W-1:0] pat, blk;
    pat = rand_blk();
    c_en = 1'b1; c_write = 1'b1; c_addr = 30'h77; c_data = pat;
    @(negedge clk);
    c_en = 1'b0; c_data = rand_blk();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (ram_en !== 1'b1 || data_to_ram !== pat || c_rdy !== 1'b0) begin
        n_fail++; $display("FAIL drop_hold got en=%b rdy=%b data=%h want 1/0/%h", ram_en, c_rdy, data_to_ram, pat);
      end
    end
    blk = rand_blk();
    ram_rdy = 1'b1; block_from_ram = blk;
    @(negedge clk);
    ram_rdy = 1'b0;
    n_tests++;
    if (c_rdy !== 1'b1 || block_out !== blk) begin
      n_fail++; $display("FAIL drop_done got rdy=%b blk=%h want 1/%h", c_rdy, block_out, blk);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({c_rdy, ram_en} !== 2'b00) begin n_fail++; $display("FAIL drop_once got rdy/en=%b want 00", {c_rdy, ram_en}); end
    end
    last_blk = blk;
  endtask

  task automatic test_priority();
    logic got[$];
    logic exp_order [10];
    logic prev_en;
    int   wait_cnt;
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    c_en = 1'b1; c_addr = 30'h1000;
    d_en = 1'b1; d_addr = 30'h2000;
    prev_en = 1'b0; wait_cnt = 0;
    for (int cyc = 0; cyc < 300 && got.size() < 10; cyc++) begin
      @(negedge clk);
      ram_rdy = 1'b0;
      n_tests++;
      if (c_rdy && d_rdy) begin n_fail++; $display("FAIL prio_both_rdy got c/d=11 want not both"); end
      if (c_rdy) c_addr = c_addr + 30'd1;
      if (d_rdy) d_addr = d_addr + 30'd1;
      if (ram_en && !prev_en) begin
        got.push_back(ram_addr >= 30'h2000);
        wait_cnt = 0;
      end else if (ram_en) begin
        wait_cnt++;
        if (wait_cnt == 2) begin ram_rdy = 1'b1; block_from_ram = rand_blk(); end
      end
      prev_en = ram_en;
    end
    n_tests++;
    if (got.size() != 10) begin
      n_fail++; $display("FAIL prio_count got=%0d want=10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (got[i] !== exp_order[i]) begin
          n_fail++; $display("FAIL prio_order[%0d] got owner=%s want %s", i, got[i] ? "D" : "C", exp_order[i] ? "D" : "C");
        end
      end
    end
    idle_inputs();
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    last_blk = '0;
  endtask

  task automatic test_random();
    req_t cq[$];
    req_t dq[$];
    req_t cur, a_c, a_d;
    int   phase, consec;
    logic own_d, a_c_en, a_d_en, a_rdy;
    logic [BLOCK_W-1:0] a_blk, exp_blk;
    phase = 0; consec = 0; own_d = 1'b0;
    a_c_en = 1'b0; a_d_en = 1'b0; a_rdy = 1'b0; a_blk = '0; exp_blk = '0;
    cur = '0; a_c = '0; a_d = '0;
    idle_inputs();
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Advance the transaction model by the edge that just happened.
      case (phase)
        0: if (a_c_en || a_d_en) begin
          own_d = a_d_en && (!a_c_en || consec >= int'(MAX_CONSEC));
          if (!own_d && a_d_en) consec = (consec < int'(MAX_CONSEC)) ? consec + 1 : consec;
          else consec = 0;
          cur = own_d ? a_d : a_c;
          phase = 1;
        end
        1: if (a_rdy) begin
          exp_blk = a_blk;
          phase = 2;
          if (own_d) void'(dq.pop_front());
          else       void'(cq.pop_front());
        end
        default: phase = 0;
      endcase
      n_tests++;
      if (ram_en !== (phase == 1)) begin n_fail++; $display("FAIL rand_en cyc=%0d got=%b want=%b", cyc, ram_en, phase == 1); end
      if (phase == 1) begin
        n_tests++;
        if ({ram_write, ram_addr, data_to_ram} !== cur) begin
          n_fail++; $display("FAIL rand_fields cyc=%0d got=%b/%h/%h want=%b/%h/%h", cyc, ram_write, ram_addr, data_to_ram, cur.wr, cur.addr, cur.data);
        end
      end
      n_tests++;
      if ({c_rdy, d_rdy} !== {phase == 2 && !own_d, phase == 2 && own_d}) begin
        n_fail++; $display("FAIL rand_rdy cyc=%0d got c/d=%b want=%b", cyc, {c_rdy, d_rdy}, {phase == 2 && !own_d, phase == 2 && own_d});
      end
      n_tests++;
      if (block_out !== exp_blk) begin n_fail++; $display("FAIL rand_block cyc=%0d got=%h want=%h", cyc, block_out, exp_blk); end
      // New stimulus for the next edge.
      if (cq.size() < 3 && $urandom_range(0, 3) == 0) cq.push_back(rand_req());
      if (dq.size() < 3 && $urandom_range(0, 3) == 0) dq.push_back(rand_req());
      if (cq.size() > 0) begin
        c_en = 1'b1; c_write = cq[0].wr; c_addr = cq[0].addr; c_data = cq[0].data; a_c = cq[0];
      end else begin
        c_en = 1'b0; c_write = 1'($urandom_range(0, 1)); c_addr = ADDR_W'($urandom()); c_data = rand_blk();
      end
      if (dq.size() > 0) begin
        d_en = 1'b1; d_write = dq[0].wr; d_addr = dq[0].addr; d_data = dq[0].data; a_d = dq[0];
      end else begin
        d_en = 1'b0; d_write = 1'($urandom_range(0, 1)); d_addr = ADDR_W'($urandom()); d_data = rand_blk();
      end
      ram_rdy = (phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      block_from_ram = rand_blk();
      a_c_en = c_en; a_d_en = d_en; a_rdy = ram_rdy; a_blk = block_from_ram;
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_c_read();
    test_d_write();
    test_spurious();
    test_reset_mid();
    test_owner_drop();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
